mem_port_arbiter: RTL

- Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads and stores).
- Grants one requester at a time, with data given priority over instruction.
- Drives a request/acknowledge handshake toward a variable-latency memory and raises per-stage stall signals for the pipeline hazard logic.
- Includes a watchdog that aborts memory transactions that never complete.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_watchdog.sv | 37 +++
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_TIMEOUT    = 15;
  localparam int unsigned DEF_MAX_D_WINS = 4;
  localparam int unsigned TO_CNT_W       = 8;
  localparam int unsigned WIN_CNT_W      = 8;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Timeout counter for outstanding memory requests; expire_o flags the busy
// cycle whose increment would make the count reach TIMEOUT.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TO_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiring on TIMEOUT-1 keeps m_req high for exactly TIMEOUT cycles.
  assign expire_o = en_i & (cnt_q == TO_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data stage over fetch stage, with a watchdog.
// Optional anti-starvation of fetch: define MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned MAX_D_WINS = DEF_MAX_D_WINS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              stall_f,
  output logic              stall_m,
  output logic              err
);

  arb_state_e        state_q, state_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;
  logic              busy, wd_en, wd_expire;
  logic              grant_i, grant_d;

  assign busy  = (state_q != IDLE);
  assign wd_en = busy & ~m_ack;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (~busy),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

`ifdef MEM_ARB_FAIRNESS_EN
  logic [WIN_CNT_W-1:0] wins_q, wins_d;

  // After MAX_D_WINS data grants in a row with fetch waiting, fetch goes next.
  assign grant_i = i_req & (~d_req | (wins_q == WIN_CNT_W'(MAX_D_WINS)));

  always_comb begin
    wins_d = wins_q;
    if (state_q == IDLE) begin
      if (grant_i) begin
        wins_d = '0;
      end else if (grant_d & i_req) begin
        wins_d = wins_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wins_q <= '0;
    end else begin
      wins_q <= wins_d;
    end
  end
`else
  logic unused_max_d_wins;

  assign grant_i           = i_req & ~d_req;
  assign unused_max_d_wins = (MAX_D_WINS == 0);
`endif

  assign grant_d = d_req & ~grant_i;

  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (grant_i) begin
          state_d  = BUSY_I;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = i_addr;
        end
      end
      BUSY_I, BUSY_D: begin
        // A completion on the expiring cycle still counts as a normal ack.
        if (m_ack) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = m_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = m_rdata;
            end
          end
        end else if (wd_expire) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          err_d   = 1'b1;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign err     = err_q;

  // Gated by reset so every output reads 0 while reset is held.
  assign stall_f = i_req & ~i_ack_q & ~reset;
  assign stall_m = d_req & ~d_ack_q & ~reset;

endmodule
